menu_controller: RTL and testbench
==================================

Name: menu_controller

Overview:
- Sequences the title/menu screen drawn by menu_display.
- Tracks which item is selected (START / SETTING), blinks the highlight on the selected item, and holds the settings values (difficulty, time limit).
- Issues a one-cycle start pulse to the game core and returns to the menu on game over.
- Sits between the debounced button inputs, the VGA frame tick and the display/game modules.

Parameters:
- BLINK_FRAMES, 30, frame ticks per highlight half-period.
- TIME_MIN, 30, minimum time limit in seconds.
- TIME_MAX, 90, maximum time limit in seconds.
- TIME_STEP, 15, time-limit increment in seconds.
- DIFF_MAX, 2, highest difficulty code (0..DIFF_MAX).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_up  in  1  debounced level, active-high.
- btn_down  in  1  debounced level.
- btn_select  in  1  debounced level.
- btn_back  in  1  debounced level.
- frame_tick  in  1  one-cycle pulse per video frame.
- game_over  in  1  one-cycle pulse from the game core.
- state  out  2  0=MENU, 1=SETTING, 2=GAME, 3=OVER.
- menu_sel  out  1  0=START, 1=SETTING.
- set_sel  out  1  settings cursor: 0=difficulty, 1=time.
- highlight  out  1  draw highlight on the selected item this frame.
- difficulty  out  2  current difficulty.
- time_limit  out  7  current time limit in seconds.
- start_pulse  out  1  one-cycle pulse on entering GAME.

Behaviour:
- Reset is synchronous and active-high; all registers update on the posedge of clk.
- Reset values:
  - state=MENU, menu_sel=0, set_sel=0, highlight=1.
  - difficulty=1, time_limit=60, start_pulse=0.
  - blink counter=0.
  - Button history registers=1, so a button held through reset produces no press until it is released.
- Press detection: press_x = btn_x & ~prev_x. prev_x is registered every cycle. Presses are acted on in the cycle they are detected; outputs change one clock later.
- Priority when several presses land in one cycle: select > back > up > down. Only the highest-priority press is acted on; the others are discarded.
- MENU state:
  - up/down toggle menu_sel; the cursor wraps, since there are only two items.
  - select with menu_sel=0: go to GAME and assert start_pulse for exactly one cycle.
  - select with menu_sel=1: go to SETTING and set set_sel=0.
  - back: ignored.
- SETTING state:
  - up/down toggle set_sel.
  - select with set_sel=0: difficulty increments, wrapping from DIFF_MAX to 0.
  - select with set_sel=1: time_limit += TIME_STEP; if the result would exceed TIME_MAX it becomes TIME_MIN.
  - back: go to MENU with menu_sel=1.
- GAME state:
  - All buttons are ignored; difficulty and time_limit are frozen.
  - game_over: go to OVER.
- OVER state:
  - select or back: go to MENU with menu_sel=0.
  - game_over while already in OVER is ignored.
- game_over in any state other than GAME is ignored.
- Blink:
  - In MENU and SETTING, each frame_tick increments the counter.
  - When the counter reaches BLINK_FRAMES-1 it clears and highlight toggles.
  - Any cursor move (menu_sel or set_sel change) or any state change forces highlight=1 and counter=0 in the same update. This takes priority over a simultaneous frame_tick.
  - In GAME and OVER, highlight=0 and the counter is held at 0.
- Arithmetic:
  - time_limit uses 7-bit unsigned math; the overflow compare is done on an 8-bit sum.
  - All values stay within [TIME_MIN, TIME_MAX] and [0, DIFF_MAX] at all times.
- Reset asserted mid-game: returns to MENU with the reset values above. start_pulse is not asserted.

Decomposition:
- Package menu_pkg holds:
  - state encodings ST_MENU/ST_SETTING/ST_GAME/ST_OVER.
  - item codes SEL_START/SEL_SETTING and SET_DIFF/SET_TIME.
  - default constants DIFF_RESET=1 and TIME_RESET=60.
- Sub-module btn_edge: history register plus rising-edge detect, with history reset to 1. It is instanced four times.
- The FSM, settings registers and blink counter stay in menu_controller.

Test Plan:
- Reset with btn_select held high, then release and press select: no action while held. The single press after release gives state=GAME and a 1-cycle start_pulse.
- From reset, press down then select: menu_sel=1, then state=SETTING, set_sel=0, highlight=1.
- In SETTING, move set_sel=1 and press select 3 times: time_limit goes 75, 90, 30. Then down to set_sel=0 and select 2 times: difficulty goes 2, 0.
- In MENU, press up and select in the same cycle: select wins, state=GAME, menu_sel unchanged at 0.
- In MENU, apply 30 frame_ticks: highlight toggles to 0 exactly on the 30th tick. Pressing down on the next cycle forces highlight=1 and the counter to 0.
- In GAME, pulse game_over: state=OVER, highlight=0. A second game_over has no effect. Pressing back gives MENU with menu_sel=0. Asserting rst mid-GAME gives MENU with difficulty=1 and time_limit=60.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared encodings and reset defaults for the title/menu screen controller.
package menu_pkg;

  typedef enum logic [1:0] {
    ST_MENU    = 2'd0,
    ST_SETTING = 2'd1,
    ST_GAME    = 2'd2,
    ST_OVER    = 2'd3
  } menu_state_t;

  localparam logic SEL_START   = 1'b0;
  localparam logic SEL_SETTING = 1'b1;
  localparam logic SET_DIFF    = 1'b0;
  localparam logic SET_TIME    = 1'b1;

  localparam logic [1:0] DIFF_RESET = 2'd1;
  localparam logic [6:0] TIME_RESET = 7'd60;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button; history resets high so a
// button held through reset only counts once it has been released.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= btn;
  end

  assign press = btn & ~prev_q;

endmodule

// File: rtl/menu_controller.sv
// Menu/settings sequencer: cursor tracking, highlight blink, settings values,
// and the start/game-over handshake with the game core.
module menu_controller
  import menu_pkg::*;
#(
  parameter int BLINK_FRAMES = 30,
  parameter int TIME_MIN     = 30,
  parameter int TIME_MAX     = 90,
  parameter int TIME_STEP    = 15,
  parameter int DIFF_MAX     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic       frame_tick,
  input  logic       game_over,
  output logic [1:0] state,
  output logic       menu_sel,
  output logic       set_sel,
  output logic       highlight,
  output logic [1:0] difficulty,
  output logic [6:0] time_limit,
  output logic       start_pulse
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic press_up, press_down, press_select, press_back;

  btn_edge u_edge_up     (.clk(clk), .rst(rst), .btn(btn_up),     .press(press_up));
  btn_edge u_edge_down   (.clk(clk), .rst(rst), .btn(btn_down),   .press(press_down));
  btn_edge u_edge_select (.clk(clk), .rst(rst), .btn(btn_select), .press(press_select));
  btn_edge u_edge_back   (.clk(clk), .rst(rst), .btn(btn_back),   .press(press_back));

  menu_state_t      state_q, state_n;
  logic             menu_sel_q, menu_sel_n;
  logic             set_sel_q, set_sel_n;
  logic             highlight_q, highlight_n;
  logic [1:0]       diff_q, diff_n;
  logic [6:0]       time_q, time_n;
  logic             start_q, start_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  // Overflow is judged on the 8-bit sum so a wrap in 7 bits cannot hide it.
  function automatic logic [6:0] next_time(input logic [6:0] cur);
    logic [7:0] sum;
    sum = {1'b0, cur} + 8'(TIME_STEP);
    if (sum > 8'(TIME_MAX)) return 7'(TIME_MIN);
    return sum[6:0];
  endfunction

  function automatic logic [1:0] next_diff(input logic [1:0] cur);
    if (cur >= 2'(DIFF_MAX)) return 2'd0;
    return cur + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MENU;
      menu_sel_q  <= SEL_START;
      set_sel_q   <= SET_DIFF;
      highlight_q <= 1'b1;
      diff_q      <= DIFF_RESET;
      time_q      <= TIME_RESET;
      start_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_n;
      menu_sel_q  <= menu_sel_n;
      set_sel_q   <= set_sel_n;
      highlight_q <= highlight_n;
      diff_q      <= diff_n;
      time_q      <= time_n;
      start_q     <= start_n;
      cnt_q       <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    menu_sel_n  = menu_sel_q;
    set_sel_n   = set_sel_q;
    highlight_n = highlight_q;
    diff_n      = diff_q;
    time_n      = time_q;
    start_n     = 1'b0;
    cnt_n       = cnt_q;

    // Only the highest-priority press is acted on: select > back > up > down.
    unique case (state_q)
      ST_MENU: begin
        if (press_select) begin
          if (menu_sel_q == SEL_START) begin
            state_n = ST_GAME;
            start_n = 1'b1;
          end else begin
            state_n   = ST_SETTING;
            set_sel_n = SET_DIFF;
          end
        end else if (press_back) begin
          state_n = ST_MENU;
        end else if (press_up || press_down) begin
          menu_sel_n = ~menu_sel_q;
        end
      end
      ST_SETTING: begin
        if (press_select) begin
          if (set_sel_q == SET_DIFF) diff_n = next_diff(diff_q);
          else                       time_n = next_time(time_q);
        end else if (press_back) begin
          state_n    = ST_MENU;
          menu_sel_n = SEL_SETTING;
        end else if (press_up || press_down) begin
          set_sel_n = ~set_sel_q;
        end
      end
      ST_GAME: begin
        if (game_over) state_n = ST_OVER;
      end
      ST_OVER: begin
        if (press_select || press_back) begin
          state_n    = ST_MENU;
          menu_sel_n = SEL_START;
        end
      end
      default: state_n = ST_MENU;
    endcase

    // Blink: any move or state change restarts the phase, beating frame_tick.
    if (state_n == ST_GAME || state_n == ST_OVER) begin
      highlight_n = 1'b0;
      cnt_n       = '0;
    end else if (state_n != state_q || menu_sel_n != menu_sel_q || set_sel_n != set_sel_q) begin
      highlight_n = 1'b1;
      cnt_n       = '0;
    end else if (frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_n       = '0;
        highlight_n = ~highlight_q;
      end else begin
        cnt_n = cnt_q + 1'b1;
      end
    end
  end

  assign state       = state_q;
  assign menu_sel    = menu_sel_q;
  assign set_sel     = set_sel_q;
  assign highlight   = highlight_q;
  assign difficulty  = diff_q;
  assign time_limit  = time_q;
  assign start_pulse = start_q;

endmodule

// File: tb/tb_menu_controller.sv
// Directed bench for menu_controller; expected outputs are queued per step and
// checked by an independent monitor on the falling edge.
module tb_menu_controller;

  logic       clk = 1'b0;
  logic       rst, btn_up, btn_down, btn_select, btn_back, frame_tick, game_over;
  logic [1:0] state;
  logic       menu_sel, set_sel, highlight, start_pulse;
  logic [1:0] difficulty;
  logic [6:0] time_limit;

  menu_controller dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_select(btn_select), .btn_back(btn_back), .frame_tick(frame_tick),
    .game_over(game_over), .state(state), .menu_sel(menu_sel), .set_sel(set_sel),
    .highlight(highlight), .difficulty(difficulty), .time_limit(time_limit),
    .start_pulse(start_pulse)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b1000000;
  localparam logic [6:0] U = 7'b0100000;
  localparam logic [6:0] D = 7'b0010000;
  localparam logic [6:0] S = 7'b0001000;
  localparam logic [6:0] B = 7'b0000100;
  localparam logic [6:0] F = 7'b0000010;
  localparam logic [6:0] G = 7'b0000001;
  localparam logic [6:0] N = 7'b0000000;

  typedef struct {
    string       name;
    logic [14:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Packs {state, menu_sel, set_sel, highlight, difficulty, time_limit, start_pulse}.
  function automatic logic [14:0] e(input logic [1:0] st, input logic ms, input logic ss,
                                    input logic hl, input logic [1:0] df,
                                    input logic [6:0] tl, input logic sp);
    return {st, ms, ss, hl, df, tl, sp};
  endfunction

  task automatic step(input logic [6:0] in, input string nm, input logic [14:0] ex);
    exp_t t;
    {rst, btn_up, btn_down, btn_select, btn_back, frame_tick, game_over} = in;
    @(posedge clk);
    #1;
    t.name = nm;
    t.val  = ex;
    exp_q.push_back(t);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t t;
      logic [14:0] act;
      t   = exp_q.pop_front();
      act = {state, menu_sel, set_sel, highlight, difficulty, time_limit, start_pulse};
      checks++;
      if (act !== t.val) begin
        errors++;
        $display("FAIL %s actual st=%0d ms=%0b ss=%0b hl=%0b diff=%0d tl=%0d sp=%0b required st=%0d ms=%0b ss=%0b hl=%0b diff=%0d tl=%0d sp=%0b",
                 t.name, act[14:13], act[12], act[11], act[10], act[9:8], act[7:1], act[0],
                 t.val[14:13], t.val[12], t.val[11], t.val[10], t.val[9:8], t.val[7:1], t.val[0]);
      end
    end
  end

  initial begin
    // Select held through reset must not count until released.
    step(R | S, "reset_hold_a", e(0, 0, 0, 1, 1, 60, 0));
    step(R | S, "reset_hold_b", e(0, 0, 0, 1, 1, 60, 0));
    step(S,     "held_no_press", e(0, 0, 0, 1, 1, 60, 0));
    step(N,     "release",       e(0, 0, 0, 1, 1, 60, 0));
    step(S,     "start_press",   e(2, 0, 0, 0, 1, 60, 1));
    step(N,     "start_one_cyc", e(2, 0, 0, 0, 1, 60, 0));
    step(G,     "game_over",     e(3, 0, 0, 0, 1, 60, 0));
    step(N,     "over_idle",     e(3, 0, 0, 0, 1, 60, 0));
    step(G,     "over_again",    e(3, 0, 0, 0, 1, 60, 0));
    step(B,     "over_back",     e(0, 0, 0, 1, 1, 60, 0));
    step(N,     "idle0",         e(0, 0, 0, 1, 1, 60, 0));

    // Menu cursor into settings.
    step(D,     "menu_down",     e(0, 1, 0, 1, 1, 60, 0));
    step(N,     "idle1",         e(0, 1, 0, 1, 1, 60, 0));
    step(S,     "enter_setting", e(1, 1, 0, 1, 1, 60, 0));
    step(N,     "idle2",         e(1, 1, 0, 1, 1, 60, 0));

    // Time limit wraps 90 -> 30, difficulty wraps 2 -> 0.
    step(D,     "set_down",      e(1, 1, 1, 1, 1, 60, 0));
    step(N,     "idle3",         e(1, 1, 1, 1, 1, 60, 0));
    step(S,     "time_75",       e(1, 1, 1, 1, 1, 75, 0));
    step(N,     "idle4",         e(1, 1, 1, 1, 1, 75, 0));
    step(S,     "time_90",       e(1, 1, 1, 1, 1, 90, 0));
    step(N,     "idle5",         e(1, 1, 1, 1, 1, 90, 0));
    step(S,     "time_wrap_30",  e(1, 1, 1, 1, 1, 30, 0));
    step(N,     "idle6",         e(1, 1, 1, 1, 1, 30, 0));
    step(D,     "set_down2",     e(1, 1, 0, 1, 1, 30, 0));
    step(N,     "idle7",         e(1, 1, 0, 1, 1, 30, 0));
    step(S,     "diff_2",        e(1, 1, 0, 1, 2, 30, 0));
    step(N,     "idle8",         e(1, 1, 0, 1, 2, 30, 0));
    step(S,     "diff_wrap_0",   e(1, 1, 0, 1, 0, 30, 0));
    step(N,     "idle9",         e(1, 1, 0, 1, 0, 30, 0));
    step(B,     "setting_back",  e(0, 1, 0, 1, 0, 30, 0));
    step(N,     "idle10",        e(0, 1, 0, 1, 0, 30, 0));

    // Select beats up in the same cycle; buttons ignored in GAME.
    step(U,     "menu_up_wrap",  e(0, 0, 0, 1, 0, 30, 0));
    step(N,     "idle11",        e(0, 0, 0, 1, 0, 30, 0));
    step(U | S, "select_wins",   e(2, 0, 0, 0, 0, 30, 1));
    step(N,     "idle12",        e(2, 0, 0, 0, 0, 30, 0));
    step(D,     "game_ign_down", e(2, 0, 0, 0, 0, 30, 0));
    step(N,     "idle13",        e(2, 0, 0, 0, 0, 30, 0));
    step(S,     "game_ign_sel",  e(2, 0, 0, 0, 0, 30, 0));
    step(N,     "idle14",        e(2, 0, 0, 0, 0, 30, 0));
    step(G,     "game_over2",    e(3, 0, 0, 0, 0, 30, 0));
    step(N,     "idle15",        e(3, 0, 0, 0, 0, 30, 0));
    step(S,     "over_select",   e(0, 0, 0, 1, 0, 30, 0));
    step(N,     "idle16",        e(0, 0, 0, 1, 0, 30, 0));

    // Blink toggles on the 30th tick; a cursor move restarts the phase.
    for (int i = 1; i <= 30; i++)
      step(F, $sformatf("blink_tick_%0d", i), e(0, 0, 0, (i < 30) ? 1'b1 : 1'b0, 0, 30, 0));
    step(D | F, "move_beats_tick", e(0, 1, 0, 1, 0, 30, 0));
    for (int i = 1; i <= 30; i++)
      step(F, $sformatf("reblink_tick_%0d", i), e(0, 1, 0, (i < 30) ? 1'b1 : 1'b0, 0, 30, 0));

    // Reset mid-game restores defaults without a start pulse.
    step(U,     "menu_up2",      e(0, 0, 0, 1, 0, 30, 0));
    step(N,     "idle17",        e(0, 0, 0, 1, 0, 30, 0));
    step(S,     "start2",        e(2, 0, 0, 0, 0, 30, 1));
    step(N,     "idle18",        e(2, 0, 0, 0, 0, 30, 0));
    step(R,     "reset_in_game", e(0, 0, 0, 1, 1, 60, 0));
    step(N,     "after_reset",   e(0, 0, 0, 1, 1, 60, 0));

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
